// File: rtl/hilo_md_ctrl.sv
// HI/LO multiply/divide sequencer: accepts MULT/MULTU/DIV/DIVU/MTHI/MTLO from EX,
// runs a 32-step shift-add multiply or restoring divide, and stalls IF..EX while busy.
module hilo_md_ctrl #(
   parameter bit MUL_FAST = 1'b0
) (
   input  logic        clk,
   input  logic        resetn,
   input  logic        op_valid,
   input  logic [2:0]  op,
   input  logic [31:0] src_a,
   input  logic [31:0] src_b,
   input  logic        flush,
   output logic        stall,
   output logic        busy,
   output logic        div_by_zero,
   output logic [31:0] hi,
   output logic [31:0] lo
);

   typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;

   state_t      state_reg;
   logic [4:0]  count_reg;
   logic [31:0] opnd_reg;     // multiplicand or divisor magnitude
   logic [31:0] low_reg;      // multiplier bits, or dividend bits becoming quotient
   logic [31:0] acc_reg;      // product upper half, or partial remainder
   logic        is_div_reg;
   logic        neg_res_reg;
   logic        neg_rem_reg;

   logic        md_req, mt_hi, mt_lo, req_signed, req_div;
   logic [31:0] a_mag, b_mag;

   assign md_req     = op_valid && !op[2];
   assign mt_hi      = op_valid && (op == 3'b100);
   assign mt_lo      = op_valid && (op == 3'b101);
   assign req_signed = !op[0];
   assign req_div    = op[1];
   assign a_mag      = (req_signed && src_a[31]) ? -src_a : src_a;
   assign b_mag      = (req_signed && src_b[31]) ? -src_b : src_b;

   assign stall = !flush && (((state_reg == IDLE) && md_req) || (state_reg == RUN));
   assign busy  = (state_reg == RUN);

   logic [32:0] mul_sum;
   logic [32:0] div_shift;
   logic [31:0] div_diff;
   logic        div_ge;
   logic [31:0] acc_next, low_next;
   logic [63:0] fast_prod, mag_res, final_res;
   logic        last_step;

   always_comb begin
      mul_sum   = {1'b0, acc_reg} + (low_reg[0] ? {1'b0, opnd_reg} : 33'd0);
      // The shifted remainder needs 33 bits; the divisor fits in 32.
      div_shift = {acc_reg, low_reg[31]};
      div_ge    = (div_shift >= {1'b0, opnd_reg});
      div_diff  = div_shift[31:0] - opnd_reg;
      if (is_div_reg) begin
         acc_next = div_ge ? div_diff : div_shift[31:0];
         low_next = {low_reg[30:0], div_ge};
      end else begin
         acc_next = mul_sum[32:1];
         low_next = {mul_sum[0], low_reg[31:1]};
      end
      fast_prod = {32'd0, opnd_reg} * {32'd0, low_reg};
      if (MUL_FAST && !is_div_reg) begin
         mag_res   = fast_prod;
         last_step = (count_reg == 5'd0);
      end else begin
         mag_res   = {acc_next, low_next};
         last_step = (count_reg == 5'd31);
      end
      if (is_div_reg) begin
         final_res[63:32] = neg_rem_reg ? -mag_res[63:32] : mag_res[63:32];
         final_res[31:0]  = neg_res_reg ? -mag_res[31:0]  : mag_res[31:0];
      end else begin
         final_res = neg_res_reg ? -mag_res : mag_res;
      end
   end

   always_ff @(posedge clk or negedge resetn) begin
      if (!resetn) begin
         state_reg   <= IDLE;
         count_reg   <= 5'd0;
         opnd_reg    <= 32'd0;
         low_reg     <= 32'd0;
         acc_reg     <= 32'd0;
         is_div_reg  <= 1'b0;
         neg_res_reg <= 1'b0;
         neg_rem_reg <= 1'b0;
         div_by_zero <= 1'b0;
         hi          <= 32'd0;
         lo          <= 32'd0;
      end else if (flush) begin
         state_reg   <= IDLE;
         count_reg   <= 5'd0;
         div_by_zero <= 1'b0;
      end else begin
         case (state_reg)
            IDLE: begin
               div_by_zero <= 1'b0;
               if (md_req) begin
                  is_div_reg  <= req_div;
                  neg_res_reg <= req_signed && (src_a[31] ^ src_b[31]);
                  neg_rem_reg <= req_signed && src_a[31];
                  acc_reg     <= 32'd0;
                  count_reg   <= 5'd0;
                  opnd_reg    <= req_div ? b_mag : a_mag;
                  low_reg     <= req_div ? a_mag : b_mag;
                  if (req_div && (src_b == 32'd0)) begin
                     state_reg   <= DONE;
                     div_by_zero <= 1'b1;
                  end else begin
                     state_reg <= RUN;
                  end
               end else if (mt_hi) begin
                  hi <= src_a;
               end else if (mt_lo) begin
                  lo <= src_a;
               end
            end
            RUN: begin
               count_reg <= count_reg + 5'd1;
               acc_reg   <= acc_next;
               low_reg   <= low_next;
               if (last_step) begin
                  hi        <= final_res[63:32];
                  lo        <= final_res[31:0];
                  state_reg <= DONE;
               end
            end
            default: begin
               // DONE: the pipeline advances this cycle, so the held op is not restarted.
               state_reg   <= IDLE;
               count_reg   <= 5'd0;
               div_by_zero <= 1'b0;
            end
         endcase
      end
   end

endmodule

// File: tb/tb_hilo_md_ctrl.sv
// Randomized bench for hilo_md_ctrl: a 64-bit arithmetic model predicts HI/LO,
// stall length and div_by_zero for a shift-add instance and a MUL_FAST instance.
module tb_hilo_md_ctrl;

   logic        clk = 1'b0;
   logic        resetn;
   logic        op_valid, flush;
   logic [2:0]  op;
   logic [31:0] src_a, src_b;
   logic        stall, busy, div_by_zero;
   logic [31:0] hi, lo;

   logic        f_op_valid, f_flush;
   logic [2:0]  f_op;
   logic [31:0] f_src_a, f_src_b;
   logic        f_stall, f_busy, f_div_by_zero;
   logic [31:0] f_hi, f_lo;

   int checks = 0;
   int errors = 0;
   logic [63:0] exp_hl [2];

   always #5 clk = ~clk;

   hilo_md_ctrl #(.MUL_FAST(1'b0)) dut (
      .clk(clk), .resetn(resetn), .op_valid(op_valid), .op(op),
      .src_a(src_a), .src_b(src_b), .flush(flush), .stall(stall),
      .busy(busy), .div_by_zero(div_by_zero), .hi(hi), .lo(lo));

   hilo_md_ctrl #(.MUL_FAST(1'b1)) dut_fast (
      .clk(clk), .resetn(resetn), .op_valid(f_op_valid), .op(f_op),
      .src_a(f_src_a), .src_b(f_src_b), .flush(f_flush), .stall(f_stall),
      .busy(f_busy), .div_by_zero(f_div_by_zero), .hi(f_hi), .lo(f_lo));

   task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
      checks++;
      if (obs !== exp) begin
         errors++;
         $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
      end
   endtask

   // Reference: plain 64-bit arithmetic; division truncates toward zero.
   function automatic logic [63:0] model(input logic [2:0] o, input logic [31:0] a,
                                         input logic [31:0] b, input logic [63:0] old);
      longint sa, sb, q, r;
      logic [63:0] p;
      sa = $signed(a);
      sb = $signed(b);
      p  = old;
      case (o)
         3'd0: p = 64'(sa * sb);
         3'd1: p = {32'd0, a} * {32'd0, b};
         3'd2: if (b != 0) begin
                  q = sa / sb;
                  r = sa % sb;
                  p = {r[31:0], q[31:0]};
               end
         3'd3: if (b != 0) p = {a % b, a / b};
         default: p = old;
      endcase
      return p;
   endfunction

   function automatic logic cur_stall(input bit f);
      return f ? f_stall : stall;
   endfunction

   task automatic set_in(input bit f, input logic v, input logic [2:0] o,
                         input logic [31:0] a, input logic [31:0] b);
      if (f) begin
         f_op_valid = v; f_op = o; f_src_a = a; f_src_b = b;
      end else begin
         op_valid = v; op = o; src_a = a; src_b = b;
      end
   endtask

   task automatic run_md(input bit f, input logic [2:0] o, input logic [31:0] a, input logic [31:0] b);
      logic [63:0] exp;
      int n, exp_n;
      bit dz;
      exp   = model(o, a, b, exp_hl[f]);
      dz    = o[1] && (b == 32'd0);
      exp_n = dz ? 1 : ((f && !o[1]) ? 2 : 33);
      @(negedge clk);
      set_in(f, 1'b1, o, a, b);
      #1;
      n = 0;
      while (cur_stall(f) && n < 100) begin
         n++;
         @(negedge clk);
         #1;
      end
      check("stall_cycles", n, exp_n);
      check("hi", f ? f_hi : hi, exp[63:32]);
      check("lo", f ? f_lo : lo, exp[31:0]);
      check("div_by_zero", f ? f_div_by_zero : div_by_zero, dz);
      $display("op=%0d fast=%0d a=%h b=%h hi=%h lo=%h stalls=%0d", o, f, a, b,
               f ? f_hi : hi, f ? f_lo : lo, n);
      exp_hl[f] = exp;
      @(negedge clk);
      set_in(f, 1'b0, 3'd0, 32'd0, 32'd0);
      #1;
      check("no_restart_busy", f ? f_busy : busy, 1'b0);
      check("dz_cleared", f ? f_div_by_zero : div_by_zero, 1'b0);
   endtask

   task automatic mt(input logic [2:0] o, input logic [31:0] a);
      @(negedge clk);
      set_in(1'b0, 1'b1, o, a, 32'd0);
      #1;
      check("mt_stall", stall, 1'b0);
      if (o == 3'b100) exp_hl[0][63:32] = a;
      else exp_hl[0][31:0] = a;
      $display("op=%0d data=%h", o, a);
   endtask

   function automatic logic [31:0] rand_word();
      case ($urandom_range(0, 5))
         0: return 32'h8000_0000;
         1: return 32'hFFFF_FFFF;
         2: return $urandom_range(0, 20);
         3: return -$urandom_range(1, 20);
         default: return $urandom;
      endcase
   endfunction

   initial begin
      resetn = 1'b0;
      flush = 1'b0; f_flush = 1'b0;
      set_in(1'b0, 1'b0, 3'd0, 32'd0, 32'd0);
      set_in(1'b1, 1'b0, 3'd0, 32'd0, 32'd0);
      exp_hl[0] = 64'd0;
      exp_hl[1] = 64'd0;
      #1;
      check("rst_hi", hi, 32'd0);
      check("rst_lo", lo, 32'd0);
      check("rst_busy", busy, 1'b0);
      check("rst_stall", stall, 1'b0);
      check("rst_dz", div_by_zero, 1'b0);
      @(negedge clk);
      resetn = 1'b1;

      run_md(1'b0, 3'd0, 32'hFFFF_FFFE, 32'h0000_0003);
      run_md(1'b0, 3'd1, 32'hFFFF_FFFF, 32'hFFFF_FFFF);
      run_md(1'b1, 3'd1, 32'hFFFF_FFFF, 32'hFFFF_FFFF);
      run_md(1'b1, 3'd0, 32'hFFFF_FFFE, 32'h0000_0003);
      run_md(1'b0, 3'd2, 32'hFFFF_FFF9, 32'd2);
      run_md(1'b0, 3'd3, 32'd7, 32'd2);
      run_md(1'b0, 3'd2, 32'h8000_0000, 32'hFFFF_FFFF);

      // MTHI/MTLO back-to-back, then divide by zero must leave them alone.
      mt(3'b100, 32'hDEAD_BEEF);
      mt(3'b101, 32'h1234_5678);
      #1;
      check("mthi_val", hi, 32'hDEAD_BEEF);
      @(negedge clk);
      set_in(1'b0, 1'b0, 3'd0, 32'd0, 32'd0);
      #1;
      check("mtlo_val", lo, 32'h1234_5678);
      mt(3'b100, 32'h11);
      mt(3'b101, 32'h22);
      @(negedge clk);
      set_in(1'b0, 1'b0, 3'd0, 32'd0, 32'd0);
      run_md(1'b0, 3'd2, 32'd5, 32'd0);

      // MTHI presented together with flush is discarded.
      @(negedge clk);
      set_in(1'b0, 1'b1, 3'b100, 32'hCAFE_0000, 32'd0);
      flush = 1'b1;
      @(negedge clk);
      set_in(1'b0, 1'b0, 3'd0, 32'd0, 32'd0);
      flush = 1'b0;
      #1;
      check("flush_mthi", hi, exp_hl[0][63:32]);

      // DIVU flushed at RUN count 10.
      @(negedge clk);
      set_in(1'b0, 1'b1, 3'd3, 32'd1000, 32'd7);
      repeat (11) @(negedge clk);
      #1;
      check("run_busy", busy, 1'b1);
      flush = 1'b1;
      #1;
      check("flush_stall", stall, 1'b0);
      @(negedge clk);
      flush = 1'b0;
      set_in(1'b0, 1'b0, 3'd0, 32'd0, 32'd0);
      #1;
      check("flush_idle", busy, 1'b0);
      check("flush_hi", hi, exp_hl[0][63:32]);
      check("flush_lo", lo, exp_hl[0][31:0]);

      for (int i = 0; i < 30; i++) begin
         logic [31:0] b;
         b = ($urandom_range(0, 7) == 0) ? 32'd0 : rand_word();
         run_md(1'b0, 3'($urandom_range(0, 3)), rand_word(), b);
      end
      for (int i = 0; i < 10; i++)
         run_md(1'b1, 3'($urandom_range(0, 1)), rand_word(), rand_word());

      // Asynchronous reset in the middle of a MULT.
      mt(3'b100, 32'h5555_AAAA);
      @(negedge clk);
      set_in(1'b0, 1'b1, 3'd0, 32'd123, 32'd456);
      repeat (5) @(negedge clk);
      #2;
      set_in(1'b0, 1'b0, 3'd0, 32'd0, 32'd0);
      resetn = 1'b0;
      #1;
      check("arst_hi", hi, 32'd0);
      check("arst_lo", lo, 32'd0);
      check("arst_busy", busy, 1'b0);
      check("arst_stall", stall, 1'b0);
      exp_hl[0] = 64'd0;
      exp_hl[1] = 64'd0;
      @(negedge clk);
      resetn = 1'b1;
      run_md(1'b0, 3'd3, 32'd100, 32'd9);

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
